// File: rtl/fft_sched.sv
// fft_sched: address scheduler for an in-place radix-2 FFT.
// For each of LOG2N stages it issues N/2 butterfly reads, one per cycle with
// no bubbles. It then idles for PIPE_LAT cycles so that the stage's writes
// land before the next stage reads. Write strobes and addresses are the read
// strobes and addresses delayed by PIPE_LAT cycles.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   i_start                    request a transform (sampled in IDLE only)
//   o_busy, o_done             transform in progress / 1-cycle completion pulse
//   o_stage                    current stage index
//   o_rd_en, o_rd_addr_a/b     butterfly read strobe and upper/lower addresses
//   o_tw_addr                  twiddle ROM address (zero-extended to 16 bits)
//   o_wr_en, o_wr_addr_a/b     butterfly result write strobe and addresses
module fft_sched #(
    parameter int unsigned LOG2N    = 10,
    parameter int unsigned PIPE_LAT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    output logic             o_busy,
    output logic             o_done,
    output logic [3:0]       o_stage,
    output logic             o_rd_en,
    output logic [LOG2N-1:0] o_rd_addr_a,
    output logic [LOG2N-1:0] o_rd_addr_b,
    output logic [15:0]      o_tw_addr,
    output logic             o_wr_en,
    output logic [LOG2N-1:0] o_wr_addr_a,
    output logic [LOG2N-1:0] o_wr_addr_b
);

    localparam int unsigned B_W    = LOG2N - 1;
    localparam int unsigned HALF_N = 1 << (LOG2N - 1);
    localparam logic [B_W-1:0] B_LAST = B_W'(HALF_N - 1);
    localparam logic [3:0]     S_LAST = 4'(LOG2N - 1);
    localparam logic [3:0]     D_LOAD = 4'(PIPE_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FIN   = 2'd3
    } state_t;

    state_t           r_state;
    logic [3:0]       r_stage;
    logic [B_W-1:0]   r_b;
    logic [3:0]       r_drain;
    logic             r_busy;
    logic             r_done;
    logic             r_rd_en;
    logic [LOG2N-1:0] r_rd_a;
    logic [LOG2N-1:0] r_rd_b;
    logic [15:0]      r_tw;

    logic [PIPE_LAT-1:0]            r_dly_en;
    logic [PIPE_LAT-1:0][LOG2N-1:0] r_dly_a;
    logic [PIPE_LAT-1:0][LOG2N-1:0] r_dly_b;

    logic [3:0]       w_iss_stage;
    logic [B_W-1:0]   w_iss_b;
    logic [LOG2N-1:0] w_bx;
    logic [LOG2N-1:0] w_mask;
    logic [LOG2N-1:0] w_pos;
    logic [LOG2N-1:0] w_addr_a;
    logic [LOG2N-1:0] w_addr_b;
    logic [15:0]      w_tw;

    // Stage/butterfly of the read issued at the next edge, if one is issued.
    always_comb begin
        w_iss_stage = 4'd0;
        w_iss_b     = '0;
        case (r_state)
            RUN: begin
                w_iss_stage = r_stage;
                w_iss_b     = r_b + B_W'(1);
            end
            DRAIN: begin
                w_iss_stage = r_stage + 4'd1;
            end
            default: begin
            end
        endcase
    end

    // Butterfly address generation: a = grp*2*half + pos, b = a + half.
    // Bit s of a is always zero, so adding half is an OR.
    always_comb begin
        w_bx     = LOG2N'(w_iss_b);
        w_mask   = (LOG2N'(1) << w_iss_stage) - LOG2N'(1);
        w_pos    = w_bx & w_mask;
        w_addr_a = ((w_bx >> w_iss_stage) << (w_iss_stage + 4'd1)) | w_pos;
        w_addr_b = w_addr_a | (LOG2N'(1) << w_iss_stage);
        w_tw     = 16'(w_pos) << (S_LAST - w_iss_stage);
    end

    // Scheduler FSM; outputs are registered and describe the current cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_stage <= 4'd0;
            r_b     <= '0;
            r_drain <= 4'd0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_rd_en <= 1'b0;
            r_rd_a  <= '0;
            r_rd_b  <= '0;
            r_tw    <= 16'd0;
        end else begin
            r_done  <= 1'b0;
            r_rd_en <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state <= RUN;
                        r_stage <= 4'd0;
                        r_b     <= '0;
                        r_busy  <= 1'b1;
                        r_rd_en <= 1'b1;
                        r_rd_a  <= w_addr_a;
                        r_rd_b  <= w_addr_b;
                        r_tw    <= w_tw;
                    end
                end
                RUN: begin
                    if (r_b == B_LAST) begin
                        r_state <= DRAIN;
                        r_b     <= '0;
                        r_drain <= D_LOAD;
                    end else begin
                        r_b     <= w_iss_b;
                        r_rd_en <= 1'b1;
                        r_rd_a  <= w_addr_a;
                        r_rd_b  <= w_addr_b;
                        r_tw    <= w_tw;
                    end
                end
                DRAIN: begin
                    if (r_drain != 4'd0) begin
                        r_drain <= r_drain - 4'd1;
                    end else if (r_stage != S_LAST) begin
                        r_state <= RUN;
                        r_stage <= w_iss_stage;
                        r_b     <= '0;
                        r_rd_en <= 1'b1;
                        r_rd_a  <= w_addr_a;
                        r_rd_b  <= w_addr_b;
                        r_tw    <= w_tw;
                    end else begin
                        r_state <= FIN;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                FIN: begin
                    // start is not sampled here, so a held start waits one IDLE cycle
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // Write delay line: free-running, cleared by reset so queued writes are lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dly_en <= '0;
            r_dly_a  <= '0;
            r_dly_b  <= '0;
        end else begin
            for (int i = PIPE_LAT - 1; i > 0; i--) begin
                r_dly_en[i] <= r_dly_en[i-1];
                r_dly_a[i]  <= r_dly_a[i-1];
                r_dly_b[i]  <= r_dly_b[i-1];
            end
            r_dly_en[0] <= r_rd_en;
            r_dly_a[0]  <= r_rd_a;
            r_dly_b[0]  <= r_rd_b;
        end
    end

    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_stage     = r_stage;
    assign o_rd_en     = r_rd_en;
    assign o_rd_addr_a = r_rd_a;
    assign o_rd_addr_b = r_rd_b;
    assign o_tw_addr   = r_tw;
    assign o_wr_en     = r_dly_en[PIPE_LAT-1];
    assign o_wr_addr_a = r_dly_a[PIPE_LAT-1];
    assign o_wr_addr_b = r_dly_b[PIPE_LAT-1];

endmodule

// File: tb/tb_fft_sched.sv
// Directed testbench for fft_sched: a small instance (N=8, PIPE_LAT=2) checked
// cycle by cycle against hand-derived address tables, plus a default-size
// instance checked for transform length and twiddle range.
module tb_fft_sched;

    logic clk;
    logic rst_n;
    logic i_start;
    logic i_start_big;

    logic       busy, done, rd_en, wr_en;
    logic [3:0] stage;
    logic [2:0] rd_a, rd_b, wr_a, wr_b;
    logic [15:0] tw;

    logic       busy_g, done_g, rd_en_g, wr_en_g;
    logic [3:0] stage_g;
    logic [9:0] rd_a_g, rd_b_g, wr_a_g, wr_b_g;
    logic [15:0] tw_g;

    int n_checks;
    int n_fail;

    fft_sched #(.LOG2N(3), .PIPE_LAT(2)) u_dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start),
        .o_busy(busy), .o_done(done), .o_stage(stage),
        .o_rd_en(rd_en), .o_rd_addr_a(rd_a), .o_rd_addr_b(rd_b), .o_tw_addr(tw),
        .o_wr_en(wr_en), .o_wr_addr_a(wr_a), .o_wr_addr_b(wr_b)
    );

    fft_sched #(.LOG2N(10), .PIPE_LAT(4)) u_big (
        .clk(clk), .rst_n(rst_n), .i_start(i_start_big),
        .o_busy(busy_g), .o_done(done_g), .o_stage(stage_g),
        .o_rd_en(rd_en_g), .o_rd_addr_a(rd_a_g), .o_rd_addr_b(rd_b_g), .o_tw_addr(tw_g),
        .o_wr_en(wr_en_g), .o_wr_addr_a(wr_a_g), .o_wr_addr_b(wr_b_g)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Butterfly order for N=8: stage 0, stage 1, stage 2 (a, b, tw).
    int exp_a[12] = '{0, 2, 4, 6, 0, 1, 4, 5, 0, 1, 2, 3};
    int exp_b[12] = '{1, 3, 5, 7, 2, 3, 6, 7, 4, 5, 6, 7};
    int exp_t[12] = '{0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        int last_idx;
        int n_rd;
        int n_wr;
        int n;
        int bad;
        int max_tw;

        n_checks    = 0;
        n_fail      = 0;
        i_start     = 1'b0;
        i_start_big = 1'b0;
        rst_n       = 1'b0;
        #12;

        // Outputs during reset
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_en", 32'(rd_en), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_addrs", {16'(tw), 4'(stage), 3'(rd_a), 3'(rd_b), 3'(wr_a), 3'(wr_b)}, 32'd0);

        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_rd_en", 32'(rd_en), 32'd0);

        // Full transform; a start pulse at k=3 while busy must be ignored.
        i_start = 1'b1;
        tick();
        i_start  = 1'b0;
        last_idx = 0;
        n_rd     = 0;
        n_wr     = 0;
        for (int k = 0; k < 20; k++) begin
            int  idx;
            int  widx;
            logic rd_exp;
            logic wr_exp;
            rd_exp = (k < 18) && ((k % 6) < 4);
            wr_exp = (k >= 2) && (k - 2 < 18) && (((k - 2) % 6) < 4);
            idx    = (k / 6) * 4 + (k % 6);
            if (rd_exp) last_idx = idx;
            chk($sformatf("busy_k%0d", k), 32'(busy), 32'(k < 18));
            chk($sformatf("done_k%0d", k), 32'(done), 32'(k == 18));
            chk($sformatf("rd_en_k%0d", k), 32'(rd_en), 32'(rd_exp));
            chk($sformatf("wr_en_k%0d", k), 32'(wr_en), 32'(wr_exp));
            if (k < 18) chk($sformatf("stage_k%0d", k), 32'(stage), 32'(k / 6));
            if (k < 18) begin
                chk($sformatf("rd_a_k%0d", k), 32'(rd_a), 32'(exp_a[last_idx]));
                chk($sformatf("rd_b_k%0d", k), 32'(rd_b), 32'(exp_b[last_idx]));
                chk($sformatf("tw_k%0d", k), 32'(tw), 32'(exp_t[last_idx]));
            end
            if (wr_exp) begin
                widx = ((k - 2) / 6) * 4 + ((k - 2) % 6);
                chk($sformatf("wr_a_k%0d", k), 32'(wr_a), 32'(exp_a[widx]));
                chk($sformatf("wr_b_k%0d", k), 32'(wr_b), 32'(exp_b[widx]));
            end
            if (rd_en) n_rd++;
            if (wr_en) n_wr++;
            i_start = (k == 3);
            tick();
        end
        i_start = 1'b0;
        chk("rd_pulses", 32'(n_rd), 32'd12);
        chk("wr_pulses", 32'(n_wr), 32'd12);

        // start held high: back-to-back transforms with one IDLE cycle between
        i_start = 1'b1;
        tick();
        n = 0;
        while (!done && n < 40) begin
            tick();
            n++;
        end
        chk("hold_done", 32'(done), 32'd1);
        chk("hold_busy_len", 32'(n), 32'd18);
        tick();
        chk("hold_gap_busy", 32'(busy), 32'd0);
        chk("hold_gap_rd_en", 32'(rd_en), 32'd0);
        tick();
        chk("hold_restart_busy", 32'(busy), 32'd1);
        chk("hold_restart_rd", {29'(rd_a), 3'(rd_b)}, {29'd0, 3'd1});
        i_start = 1'b0;

        // Reset in the middle of stage 1
        for (int i = 0; i < 7; i++) tick();
        chk("pre_rst_stage", 32'(stage), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'd0);
        chk("arst_rd_en", 32'(rd_en), 32'd0);
        chk("arst_wr_en", 32'(wr_en), 32'd0);
        chk("arst_addrs", {16'(tw), 4'(stage), 3'(rd_a), 3'(rd_b), 3'(wr_a), 3'(wr_b)}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (wr_en || rd_en || busy) bad++;
        end
        chk("post_rst_quiet", 32'(bad), 32'd0);

        // First start after reset begins at stage 0
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("re_stage_k%0d", k), 32'(stage), 32'd0);
            chk($sformatf("re_rd_k%0d", k), {16'(tw), 8'(rd_a), 8'(rd_b)},
                {16'(exp_t[k]), 8'(exp_a[k]), 8'(exp_b[k])});
            tick();
        end

        // Default size: transform length and twiddle range
        i_start_big = 1'b1;
        tick();
        i_start_big = 1'b0;
        n      = 0;
        max_tw = 0;
        while (busy_g && n < 6000) begin
            if (rd_en_g && int'(tw_g) > max_tw) max_tw = int'(tw_g);
            n++;
            tick();
        end
        chk("big_busy_len", 32'(n), 32'd5160);
        chk("big_done", 32'(done_g), 32'd1);
        chk("big_max_tw", 32'(max_tw), 32'd511);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fft_sched.md
FFT_SCHED -- requirements
Module: fft_sched

Interface
REQ-001 Parameter LOG2N, default 10: log2 of FFT length N; legal 2..15; twiddle table depth is N/2.
REQ-002 Parameter PIPE_LAT, default 4: cycles from butterfly read issue to result write; legal 1..15.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst_n  in  1  asynchronous, active-low reset.
REQ-005 start  in  1  request a full N-point transform; sampled only in IDLE.
REQ-006 busy  out  1  high from the cycle after start is accepted until done.
REQ-007 done  out  1  single-cycle completion pulse.
REQ-008 stage  out  4  current stage index, 0..LOG2N-1.
REQ-009 rd_en  out  1  butterfly read issue strobe.
REQ-010 rd_addr_a / rd_addr_b  out  LOG2N each  butterfly input addresses, upper and lower leg.
REQ-011 tw_addr  out  16  twiddle ROM address, zero-extended, valid when rd_en is high.
REQ-012 wr_en  out  1  butterfly result write strobe.
REQ-013 wr_addr_a / wr_addr_b  out  LOG2N each  result write addresses.

Function
REQ-014 FSM states are IDLE, RUN, DRAIN and FIN, and the FSM is in IDLE after reset.
REQ-015 IDLE: start=1 -> RUN with stage=0 and butterfly counter b=0; start=0 -> stay IDLE.
REQ-016 RUN: issues one butterfly per cycle with rd_en=1, b = 0..N/2-1, and has no bubbles.
REQ-017 Address rules, per stage s: half=2^s; pos=b mod half; grp=b div half; rd_addr_a=grp*2*half+pos; rd_addr_b=rd_addr_a+half; tw_addr=pos*2^(LOG2N-1-s).
REQ-018 RUN, b=N/2-1 -> DRAIN with b cleared and the drain counter loaded.
REQ-019 DRAIN holds rd_en=0 for exactly PIPE_LAT cycles, to prevent read-after-write across stages.
REQ-020 DRAIN end, stage<LOG2N-1 -> stage+1, RUN.
REQ-021 DRAIN end, stage=LOG2N-1 -> FIN.
REQ-022 FIN lasts 1 cycle with done=1 and busy=0, then -> IDLE.
REQ-023 wr_en, wr_addr_a and wr_addr_b are rd_en, rd_addr_a and rd_addr_b delayed by exactly PIPE_LAT cycles through a shift register.
REQ-024 The write delay line keeps running in every state.
REQ-025 start is ignored while busy=1, and start held high through FIN does not retrigger until IDLE is reached.
REQ-026 rd_addr_a, rd_addr_b and tw_addr hold their last values when rd_en=0.
REQ-027 A transform takes exactly LOG2N*(N/2+PIPE_LAT) cycles of busy=1, followed by 1 FIN cycle.
REQ-028 tw_addr is registered, and the twiddle ROM output (1-cycle ROM latency) aligns with read data one cycle after rd_en.

Reset
REQ-029 rst_n=0 immediately forces IDLE, stage=0, b=0, drain counter=0 and the delay line cleared.
REQ-030 While rst_n=0, all outputs are 0 (busy, done, rd_en, wr_en, all addresses, tw_addr, stage).
REQ-031 Reset mid-transform aborts with no further rd_en or wr_en, including writes already in the delay line.
REQ-032 After rst_n rises, the first accepted start begins at stage 0.

Verification (LOG2N=3, PIPE_LAT=2 unless stated)
REQ-033 Stage 0: start pulse -> (a,b,tw) = (0,1,0),(2,3,0),(4,5,0),(6,7,0) on 4 consecutive rd_en cycles.
REQ-034 Stage 1: start pulse -> after 2 idle cycles, (0,2,0),(1,3,2),(4,6,0),(5,7,2).
REQ-035 Stage 2: start pulse -> after 2 idle cycles, (0,4,0),(1,5,1),(2,6,2),(3,7,3).
REQ-036 Full transform: start pulse -> busy=1 for 18 cycles, done=1 for 1 cycle, 12 rd_en pulses and 12 wr_en pulses.
REQ-037 Write delay: each wr_en and its write addresses equal rd_en and its read addresses 2 cycles earlier.
REQ-038 Write ordering: the last write of a stage precedes the first read of the next stage.
REQ-039 start held high continuously -> back-to-back transforms with one IDLE cycle between done and the next busy.
REQ-040 start pulsed while busy -> no effect.
REQ-041 rst_n pulsed low during stage 1 -> all outputs 0 asynchronously, no wr_en afterwards.
REQ-042 After that reset, a new start produces the REQ-033 sequence.
REQ-043 LOG2N=10, PIPE_LAT=4: busy=1 for 5160 cycles.
REQ-044 LOG2N=10, PIPE_LAT=4: the maximum tw_addr observed is 511.
